// File: rtl/multiplier_fp_param.sv
// Parameterised IEEE-754-style floating-point multiplier.
// A multi-cycle FSM unpacks the operands, multiplies the significands with a
// shift-add loop (one multiplier bit per cycle), normalises, and rounds to
// nearest-even.
//
// Optional feature macro: FPMUL_SUBNORMAL_EN
//   defined   : subnormal inputs are used as 0.man * 2^(1-BIAS), and tiny
//               results are denormalised into subnormal outputs.
//   undefined : subnormal inputs and tiny results are flushed to signed zero.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start_i               operation request (accepted only when idle)
//   a_i, b_i [W-1:0]      operands {sign, exp, man}
//   product_o [W-1:0]     result, held until the next accepted start
//   done_o                one-cycle completion pulse
//   busy_o                operation in flight
//   nan_o, infinit_o, overflow_o, underflow_o, inexact_o   result flags
module multiplier_fp_param #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W,
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] product_o,
  output logic         done_o,
  output logic         busy_o,
  output logic         nan_o,
  output logic         infinit_o,
  output logic         overflow_o,
  output logic         underflow_o,
  output logic         inexact_o
);

`ifdef FPMUL_SUBNORMAL_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  localparam int N  = MAN_W + 1;        // significand width incl. hidden bit
  localparam int PW = 2 * N;            // raw product width
  localparam int LW = $clog2(PW);
  localparam int CW = $clog2(N + 1);
  // Exponent arithmetic is widened beyond EXP_W+2 so that the normalisation
  // offset of a product of two subnormals cannot wrap.
  localparam int EW = EXP_W + 3 + LW;

  typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, DONE} state_t;
  state_t state, state_nx;

  logic [W-1:0]  a_r, b_r;
  logic [PW-1:0] mcand, acc, nm;
  logic [N-1:0]  mplier;
  logic [CW-1:0] cnt;
  logic [EW-1:0] exp_r;

  // ---- unpack / classify ----
  logic [EXP_W-1:0] a_exp, b_exp, a_e, b_e;
  logic [MAN_W-1:0] a_man, b_man;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_den, b_den;
  logic is_nan, special, sgn;
  logic [N-1:0]  a_sig, b_sig;
  logic [EW-1:0] e_sum;

  always_comb begin
    a_exp  = a_r[W-2:MAN_W];
    b_exp  = b_r[W-2:MAN_W];
    a_man  = a_r[MAN_W-1:0];
    b_man  = b_r[MAN_W-1:0];
    a_nan  = (&a_exp) && (a_man != '0);
    b_nan  = (&b_exp) && (b_man != '0);
    a_inf  = (&a_exp) && (a_man == '0);
    b_inf  = (&b_exp) && (b_man == '0);
    a_den  = (a_exp == '0) && (a_man != '0);
    b_den  = (b_exp == '0) && (b_man != '0);
    a_zero = (a_exp == '0) && ((a_man == '0) || !SUB_EN);
    b_zero = (b_exp == '0) && ((b_man == '0) || !SUB_EN);
    is_nan = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    special = is_nan || a_inf || b_inf || a_zero || b_zero;
    sgn    = a_r[W-1] ^ b_r[W-1];
    // subnormals carry a 0 hidden bit and the minimum exponent
    a_sig  = {a_exp != '0, a_man};
    b_sig  = {b_exp != '0, b_man};
    a_e    = (a_exp == '0) ? EXP_W'(1) : a_exp;
    b_e    = (b_exp == '0) ? EXP_W'(1) : b_exp;
    e_sum  = EW'(a_e) + EW'(b_e) - EW'(BIAS);
  end

  // ---- leading-one position of the raw product ----
  logic [LW-1:0] lead;
  always_comb begin
    lead = '0;
    for (int i = 0; i < PW; i++)
      if (acc[i]) lead = LW'(i);
  end

  // ---- round: optional denormalising shift, then RNE on guard/round/sticky ----
  logic          tiny, g, r, s, inc, lost, inx, ovf;
  logic [EW-1:0] sh, e_r, e_fin;
  logic [PW-1:0] shifted;
  logic [N-1:0]  kept;
  logic [N:0]    mant;
  logic [EXP_W-1:0] exp_field;
  logic [MAN_W-1:0] man_field;

  always_comb begin
    tiny    = exp_r[EW-1] || (exp_r == '0);
    sh      = tiny ? (EW'(1) - exp_r) : '0;
    shifted = nm >> sh;
    lost    = |(nm & ~({PW{1'b1}} << sh));
    kept    = shifted[PW-1 -: N];
    g       = shifted[N-1];
    r       = shifted[N-2];
    s       = (|shifted[N-3:0]) || lost;
    inc     = g && (r || s || kept[0]);
    inx     = g || r || s;
    mant    = {1'b0, kept} + {{N{1'b0}}, inc};
    e_r     = tiny ? EW'(1) : exp_r;
    e_fin   = e_r + {{(EW-1){1'b0}}, mant[N]};
    ovf     = !e_fin[EW-1] && (e_fin >= EW'((1 << EXP_W) - 1));
    // a cleared hidden bit after rounding means the result stays subnormal
    exp_field = (mant[N] || mant[N-1]) ? e_fin[EXP_W-1:0] : '0;
    man_field = mant[N] ? '0 : mant[MAN_W-1:0];
  end

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i) state_nx = UNPACK;
      UNPACK:  state_nx = special ? DONE : MULT;
      MULT:    if (cnt == CW'(N - 1)) state_nx = NORM;
      NORM:    state_nx = ROUND;
      ROUND:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---- datapath and registered outputs ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      product_o <= '0; done_o <= 1'b0; busy_o <= 1'b0;
      nan_o <= 1'b0; infinit_o <= 1'b0; overflow_o <= 1'b0;
      underflow_o <= 1'b0; inexact_o <= 1'b0;
      a_r <= '0; b_r <= '0; mcand <= '0; mplier <= '0; acc <= '0;
      nm <= '0; cnt <= '0; exp_r <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          a_r <= a_i; b_r <= b_i;
          product_o <= '0; busy_o <= 1'b1;
          nan_o <= 1'b0; infinit_o <= 1'b0; overflow_o <= 1'b0;
          underflow_o <= 1'b0; inexact_o <= 1'b0;
        end
        UNPACK: begin
          if (is_nan) begin
            product_o <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            nan_o     <= 1'b1;
          end else if (a_inf || b_inf) begin
            product_o <= {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            infinit_o <= 1'b1;
          end else if (special) begin
            product_o   <= {sgn, {(W-1){1'b0}}};
            // a flushed subnormal operand is reported as an underflow
            underflow_o <= !SUB_EN && (a_den || b_den);
          end
          mcand  <= {{N{1'b0}}, a_sig};
          mplier <= b_sig;
          acc    <= '0;
          cnt    <= '0;
          exp_r  <= e_sum;
        end
        MULT: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        NORM: begin
          // leading one to the top; bit 2*MAN_W is the 1.0 position
          nm    <= acc << (LW'(PW - 1) - lead);
          exp_r <= exp_r + EW'(lead) - EW'(2 * MAN_W);
        end
        ROUND: begin
          if (ovf) begin
            product_o  <= {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            overflow_o <= 1'b1; infinit_o <= 1'b1; inexact_o <= 1'b1;
          end else if (tiny && !SUB_EN) begin
            product_o   <= {sgn, {(W-1){1'b0}}};
            underflow_o <= 1'b1; inexact_o <= 1'b1;
          end else begin
            product_o   <= {sgn, exp_field, man_field};
            inexact_o   <= inx;
            underflow_o <= tiny && inx;
          end
        end
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
